arc_seq: RTL and testbench

Word-timing and instruction-issue sequencer for the ARC arithmetic/register chip. Generates the 56-bit-time system word, the sync window, the bit-serial instruction stream `is` and the word-select `ws` field enable from a parallel 10-bit instruction source and a 4-bit digit pointer. It replaces ad-hoc bench timing and is the block that drives ARC in the full calculator build.

---
 rtl/arc_seq_if.sv | 27 ++
 rtl/arc_seq.sv | 155 +++++++++++++++
 tb/tb_arc_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arc_seq_if.sv
// Bus bundle for arc_seq: instruction source, pointer command and all
// sequencer outputs. master = instruction/pointer source, slave = arc_seq.
interface arc_seq_if;
    logic [9:0] inst_data;
    logic       inst_valid;
    logic       inst_ready;
    logic [1:0] ptr_op;
    logic [3:0] ptr_val;
    logic [5:0] bit_cnt;
    logic       word_start;
    logic [7:0] addr;
    logic       sync;
    logic       is;
    logic       ws;
    logic [3:0] ptr;
    logic       underrun;

    modport master (
        output inst_data, inst_valid, ptr_op, ptr_val,
        input  inst_ready, bit_cnt, word_start, addr, sync, is, ws, ptr, underrun
    );

    modport slave (
        input  inst_data, inst_valid, ptr_op, ptr_val,
        output inst_ready, bit_cnt, word_start, addr, sync, is, ws, ptr, underrun
    );
endinterface

// File: rtl/arc_seq.sv
// ARC word-timing and instruction-issue sequencer: 56-bit-time word, sync
// window, serial instruction stream and word-select. Option: ARC_SEQ_WS_GATE_EN.
module arc_seq #(
    parameter int WORD_BITS  = 56,
    parameter int SYNC_FIRST = 45
) (
    input  logic     cph2,
    input  logic     rstn,
    arc_seq_if.slave bus
);

    localparam logic [5:0] LAST_BIT  = 6'(WORD_BITS - 1);
    // Latching on the edge out of bit 43 makes inst_ready a registered pulse
    // that sits exactly in the bit-44 cycle, with no input-to-output path.
    localparam logic [5:0] FETCH_BIT = 6'(SYNC_FIRST - 2);
    localparam logic [5:0] SYNC_LO   = 6'(SYNC_FIRST);
    localparam logic [5:0] SYNC_HI   = 6'(SYNC_FIRST + 9);
    localparam logic [3:0] PTR_MAX   = 4'd13;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    logic [5:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] addr_q,     addr_d;
    logic [9:0] issue_q,    issue_d;
    logic       ready_q,    ready_d;
    logic       underrun_q, underrun_d;
    logic [2:0] type_q,     type_d;
    logic       arith_q,    arith_d;
    logic [3:0] ptr_q,      ptr_d;

    logic       wrap_s;
    logic       fetch_s;
    logic [3:0] digit_s;
    logic [3:0] sync_idx_s;
    logic       sync_s;
    logic       is_s;
    logic       ws_raw_s;
    logic       ws_s;

    function automatic logic [3:0] ptr_next(input logic [3:0] cur,
                                            input logic [1:0] op,
                                            input logic [3:0] val);
        logic [3:0] res;
        case (op)
            OP_NONE: res = cur;
            OP_SET:  res = (val > PTR_MAX) ? PTR_MAX : val;
            OP_INC:  res = (cur >= PTR_MAX) ? 4'd0 : cur + 4'd1;
            OP_DEC:  res = (cur == 4'd0) ? PTR_MAX : cur - 4'd1;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Next-state: bit counter, fetch into issue register, word-wrap activation.
    always_comb begin
        wrap_s     = (bit_cnt_q == LAST_BIT);
        fetch_s    = (bit_cnt_q == FETCH_BIT);
        bit_cnt_d  = wrap_s ? 6'd0 : bit_cnt_q + 6'd1;
        addr_d     = addr_q;
        issue_d    = issue_q;
        ready_d    = 1'b0;
        underrun_d = underrun_q;
        type_d     = type_q;
        arith_d    = arith_q;
        ptr_d      = ptr_q;

        if (fetch_s) begin
            if (bus.inst_valid) begin
                issue_d = bus.inst_data;
                ready_d = 1'b1;
            end else begin
                issue_d    = 10'h000;
                underrun_d = 1'b1;
            end
        end else begin
            issue_d = issue_q;
        end

        if (wrap_s) begin
            addr_d  = addr_q + 8'd1;
            type_d  = issue_q[4:2];
            arith_d = (issue_q[1:0] == 2'b10);
            ptr_d   = ptr_next(ptr_q, bus.ptr_op, bus.ptr_val);
        end else begin
            addr_d = addr_q;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge cph2 or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q  <= 6'd0;
            addr_q     <= 8'd0;
            issue_q    <= 10'h000;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            type_q     <= 3'b000;
            arith_q    <= 1'b0;
            ptr_q      <= 4'd0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            type_q     <= type_d;
            arith_q    <= arith_d;
            ptr_q      <= ptr_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        digit_s    = bit_cnt_q[5:2];
        sync_s     = (bit_cnt_q >= SYNC_LO) && (bit_cnt_q <= SYNC_HI);
        sync_idx_s = 4'(bit_cnt_q - SYNC_LO);
        if (sync_s) begin
            is_s = issue_q[sync_idx_s];
        end else begin
            is_s = 1'b0;
        end

        case (type_q)
            3'b000:  ws_raw_s = (digit_s == ptr_q);
            3'b001:  ws_raw_s = (digit_s >= 4'd3) && (digit_s <= 4'd12);
            3'b010:  ws_raw_s = (digit_s <= 4'd2);
            3'b011:  ws_raw_s = 1'b1;
            3'b100:  ws_raw_s = (digit_s <= ptr_q);
            3'b101:  ws_raw_s = (digit_s >= 4'd3) && (digit_s <= 4'd13);
            3'b110:  ws_raw_s = (digit_s == 4'd2);
            3'b111:  ws_raw_s = (digit_s == 4'd13);
            default: ws_raw_s = 1'b0;
        endcase

`ifdef ARC_SEQ_WS_GATE_EN
        ws_s = ws_raw_s & arith_q;
`else
        ws_s = ws_raw_s;
`endif
    end

    assign bus.bit_cnt    = bit_cnt_q;
    assign bus.word_start = (bit_cnt_q == 6'd0);
    assign bus.addr       = addr_q;
    assign bus.sync       = sync_s;
    assign bus.is         = is_s;
    assign bus.ws         = ws_s;
    assign bus.ptr        = ptr_q;
    assign bus.underrun   = underrun_q;
    assign bus.inst_ready = ready_q;

endmodule

// File: tb/tb_arc_seq.sv
// Scoreboard bench for arc_seq: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_arc_seq;

    localparam int S_IS = 0, S_WS = 1, S_SYNC = 2, S_RDY = 3, S_BC = 4,
                   S_WST = 5, S_ADDR = 6, S_PTR = 7, S_UND = 8;

    typedef struct {
        int    tag;
        int    sig;
        int    exp;
        string name;
    } exp_t;

    typedef struct {
        logic [9:0]  data;
        bit          valid;
        logic [1:0]  pop;
        logic [3:0]  pval;
        bit          pop_mid;
        logic [3:0]  ptr_next;
        logic [13:0] mask;
        bit          arith;
        bit          und;
    } word_t;

    logic cph2 = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_addr = 0;
    exp_t q[$];
    word_t vec[11];
    word_t w12;

    arc_seq_if bus_if ();

    arc_seq u_dut (
        .cph2 (cph2),
        .rstn (rstn),
        .bus  (bus_if)
    );

    always #5 cph2 = ~cph2;

    always @(posedge cph2) cyc = cyc + 1;

    function automatic word_t mk(logic [9:0] d, bit v, logic [1:0] op, logic [3:0] pv,
                                 bit mid, logic [3:0] pn, logic [13:0] m, bit ar, bit un);
        word_t w;
        w.data = d; w.valid = v; w.pop = op; w.pval = pv; w.pop_mid = mid;
        w.ptr_next = pn; w.mask = m; w.arith = ar; w.und = un;
        return w;
    endfunction

    function automatic int ws_exp(logic [13:0] m, bit ar, int k);
`ifdef ARC_SEQ_WS_GATE_EN
        if (!ar) return 0;
`endif
        return int'(m[k / 4]);
    endfunction

    function automatic int sample(int s);
        case (s)
            S_IS:    return int'(bus_if.is);
            S_WS:    return int'(bus_if.ws);
            S_SYNC:  return int'(bus_if.sync);
            S_RDY:   return int'(bus_if.inst_ready);
            S_BC:    return int'(bus_if.bit_cnt);
            S_WST:   return int'(bus_if.word_start);
            S_ADDR:  return int'(bus_if.addr);
            S_PTR:   return int'(bus_if.ptr);
            S_UND:   return int'(bus_if.underrun);
            default: return -1;
        endcase
    endfunction

    task automatic push(int tag, int sig, int exp, string name);
        exp_t e;
        int   pos;
        e.tag = tag; e.sig = sig; e.exp = exp; e.name = name;
        pos = q.size();
        while (pos > 0 && q[pos-1].tag > tag) pos--;
        q.insert(pos, e);
    endtask

    task automatic purge_from(int tag);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].tag >= tag) q.delete(i);
        end
    endtask

    task automatic wait_until(int t);
        while (cyc < t) begin
            @(posedge cph2);
            #1;
        end
    endtask

    task automatic push_ws_word(int b, logic [13:0] m, bit ar);
        for (int k = 0; k < 56; k++) push(b + k, S_WS, ws_exp(m, ar, k), $sformatf("ws[%0d]", k));
    endtask

    // Monitor: compare every expectation whose cycle has come.
    always @(negedge cph2) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            exp_t e;
            int   got;
            e = q.pop_front();
            checks++;
            if (e.tag < cyc) begin
                errors++;
                $display("FAIL %s missed at cycle %0d (now %0d)", e.name, e.tag, cyc);
            end else begin
                got = sample(e.sig);
                if (got != e.exp) begin
                    errors++;
                    $display("FAIL %s cycle=%0d got=%0d exp=%0d", e.name, e.tag, got, e.exp);
                end
            end
        end
    end

    task automatic run_word(input word_t w);
        int         b;
        logic [9:0] eff;
        b = cyc;
        eff = w.valid ? w.data : 10'h000;
        bus_if.inst_data  = w.data;
        bus_if.inst_valid = w.valid;
        bus_if.ptr_val    = w.pval;
        bus_if.ptr_op     = w.pop_mid ? 2'b00 : w.pop;
        push(b, S_BC, 0, "bit_cnt0");
        push(b, S_WST, 1, "word_start");
        push(b, S_ADDR, exp_addr, "addr");
        push(b + 43, S_RDY, 0, "ready@43");
        push(b + 44, S_RDY, int'(w.valid), "ready@44");
        push(b + 44, S_BC, 44, "bit_cnt44");
        push(b + 44, S_SYNC, 0, "sync@44");
        for (int i = 0; i < 10; i++) begin
            push(b + 45 + i, S_IS, int'(eff[i]), $sformatf("is[%0d]", i));
            push(b + 45 + i, S_SYNC, 1, "sync_in");
        end
        push(b + 55, S_SYNC, 0, "sync@55");
        push(b + 55, S_IS, 0, "is@55");
        push(b + 50, S_UND, int'(w.und), "underrun");
        push(b + 56, S_PTR, int'(w.ptr_next), "ptr");
        push_ws_word(b + 56, w.mask, w.arith);
        if (w.pop_mid) begin
            wait_until(b + 20);
            bus_if.ptr_op = w.pop;
            wait_until(b + 21);
            bus_if.ptr_op = 2'b00;
        end
        wait_until(b + 56);
        exp_addr++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        vec[0]  = mk(10'b11101_010_00, 1'b1, 2'b00, 4'd0,  1'b0, 4'd0,  14'h0007, 1'b0, 1'b0);
        vec[1]  = mk(10'b11111_000_10, 1'b1, 2'b01, 4'd3,  1'b0, 4'd3,  14'h0008, 1'b1, 1'b0);
        vec[2]  = mk(10'b00000_100_10, 1'b1, 2'b01, 4'd5,  1'b0, 4'd5,  14'h003F, 1'b1, 1'b0);
        vec[3]  = mk(10'b00001_101_10, 1'b1, 2'b00, 4'd0,  1'b0, 4'd5,  14'h3FF8, 1'b1, 1'b0);
        vec[4]  = mk(10'b10101_011_01, 1'b1, 2'b01, 4'd13, 1'b0, 4'd13, 14'h3FFF, 1'b0, 1'b0);
        vec[5]  = mk(10'b01010_000_10, 1'b1, 2'b10, 4'd0,  1'b0, 4'd0,  14'h0001, 1'b1, 1'b0);
        vec[6]  = mk(10'b10011_111_10, 1'b1, 2'b11, 4'd0,  1'b0, 4'd13, 14'h2000, 1'b1, 1'b0);
        vec[7]  = mk(10'b01100_110_11, 1'b1, 2'b01, 4'd15, 1'b0, 4'd13, 14'h0004, 1'b0, 1'b0);
        vec[8]  = mk(10'b11000_001_10, 1'b1, 2'b10, 4'd0,  1'b1, 4'd13, 14'h1FF8, 1'b1, 1'b0);
        vec[9]  = mk(10'b11111_111_11, 1'b0, 2'b01, 4'd2,  1'b0, 4'd2,  14'h0004, 1'b0, 1'b1);
        vec[10] = mk(10'b00110_010_10, 1'b1, 2'b00, 4'd0,  1'b0, 4'd2,  14'h0007, 1'b1, 1'b1);
        w12     = mk(10'b00111_011_10, 1'b1, 2'b01, 4'd7,  1'b0, 4'd7,  14'h3FFF, 1'b1, 1'b0);

        bus_if.inst_data  = 10'h000;
        bus_if.inst_valid = 1'b0;
        bus_if.ptr_op     = 2'b00;
        bus_if.ptr_val    = 4'd0;

        // Reset state while rstn is held low.
        wait_until(1);
        push(1, S_BC, 0, "rst_bit_cnt");
        push(1, S_WST, 1, "rst_word_start");
        push(1, S_ADDR, 0, "rst_addr");
        push(1, S_SYNC, 0, "rst_sync");
        push(1, S_IS, 0, "rst_is");
        push(1, S_RDY, 0, "rst_ready");
        push(1, S_UND, 0, "rst_underrun");
        push(1, S_PTR, 0, "rst_ptr");
        push(1, S_WS, ws_exp(14'h0001, 1'b0, 0), "rst_ws");
        wait_until(2);
        rstn = 1'b1;

        push_ws_word(cyc, 14'h0001, 1'b0);
        for (int n = 0; n < 11; n++) run_word(vec[n]);

        // Mid-word reset at bit 50 of a word carrying an all-ones instruction.
        b = cyc;
        bus_if.inst_data  = 10'b11111_111_11;
        bus_if.inst_valid = 1'b1;
        bus_if.ptr_op     = 2'b00;
        push(b, S_ADDR, exp_addr, "addr_pre_rst");
        push(b + 30, S_UND, 1, "underrun_sticky");
        push(b + 44, S_RDY, 1, "ready_pre_rst");
        push(b + 49, S_SYNC, 1, "sync_pre_rst");
        push(b + 49, S_IS, 1, "is_pre_rst");
        wait_until(b + 50);
        purge_from(b + 50);
        rstn = 1'b0;
        push(b + 50, S_IS, 0, "mid_rst_is");
        push(b + 50, S_SYNC, 0, "mid_rst_sync");
        push(b + 50, S_PTR, 0, "mid_rst_ptr");
        push(b + 50, S_ADDR, 0, "mid_rst_addr");
        push(b + 50, S_UND, 0, "mid_rst_underrun");
        push(b + 50, S_BC, 0, "mid_rst_bit_cnt");
        push(b + 50, S_RDY, 0, "mid_rst_ready");
        wait_until(b + 52);
        rstn = 1'b1;
        exp_addr = 0;
        push_ws_word(cyc, 14'h0001, 1'b0);
        run_word(w12);

        bus_if.inst_valid = 1'b0;
        for (int i = 0; i < 200 && q.size() > 0; i++) begin
            @(posedge cph2);
            #1;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
